// File: rtl/led_pkg.sv
// Shared definitions for the LED PWM driver / capture family.
//   cap_state_e : capture FSM encoding (IDLE, HIGH, LOW)
//   T10MS       : cycles in 10 ms at the 50 MHz system clock
//   CNT_W_DEF   : default counter/result width
package led_pkg;

    localparam int unsigned CNT_W_DEF = 21;
    localparam int unsigned T10MS     = 500_000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } cap_state_e;

endpackage

// File: rtl/sync_edge_module.sv
// Three-flop synchroniser for an asynchronous input, with single-cycle
// rise/fall pulses derived from the two oldest stages.
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset (flops clear to 0)
//   sig_i   asynchronous input
//   rise_o  one-cycle pulse on a synchronised 0->1 transition
//   fall_o  one-cycle pulse on a synchronised 1->0 transition
module sync_edge_module (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    // sync_q[0] = s1 (metastability catcher), sync_q[1] = s2, sync_q[2] = s3
    logic [2:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], sig_i};
        end
    end

    assign rise_o =  sync_q[1] & ~sync_q[2];
    assign fall_o = ~sync_q[1] &  sync_q[2];

endmodule

// File: rtl/pwm_capture_module.sv
// Measures an asynchronous pulse train: high-phase width and rise-to-rise
// period, in CLK cycles, reported once per completed period. A period that
// exceeds T_TIMEOUT cycles abandons the measurement and raises Timeout_Sig.
// Ports:
//   CLK           system clock
//   RSTn          asynchronous active-low reset
//   Sig_In        asynchronous pulse input
//   High_Count    high width of the last complete period
//   Period_Count  period of the last complete period
//   Done_Sig      one-cycle pulse when both results update
//   Timeout_Sig   level, set when a measurement is abandoned; cleared by the
//                 next rise that opens a new measurement
module pwm_capture_module
    import led_pkg::*;
#(
    parameter int unsigned      CNT_W     = CNT_W_DEF,
    parameter logic [CNT_W-1:0] T_TIMEOUT = CNT_W'(21'h1F_FFFF)
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             Sig_In,
    output logic [CNT_W-1:0] High_Count,
    output logic [CNT_W-1:0] Period_Count,
    output logic             Done_Sig,
    output logic             Timeout_Sig
);

    logic rise, fall;

    sync_edge_module u_sync (
        .clk_i  (CLK),
        .rst_ni (RSTn),
        .sig_i  (Sig_In),
        .rise_o (rise),
        .fall_o (fall)
    );

    cap_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] high_tmp_q, high_tmp_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic             done_q, done_d;
    logic             to_q, to_d;

    logic             at_lim;
    logic [CNT_W-1:0] cnt_inc;

    // Saturate at the limit: an edge arriving exactly at the limit still
    // completes normally, and the counter never passes T_TIMEOUT.
    assign at_lim  = (cnt_q == T_TIMEOUT);
    assign cnt_inc = at_lim ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            high_tmp_q <= '0;
            high_q     <= '0;
            per_q      <= '0;
            done_q     <= 1'b0;
            to_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            high_tmp_q <= high_tmp_d;
            high_q     <= high_d;
            per_q      <= per_d;
            done_q     <= done_d;
            to_q       <= to_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        high_tmp_d = high_tmp_q;
        high_d     = high_q;
        per_d      = per_q;
        done_d     = 1'b0;
        to_d       = to_q;

        unique case (state_q)
            IDLE: begin
                // Counter frozen; a fall here is ignored. The first rise
                // only opens a measurement.
                if (rise) begin
                    state_d = HIGH;
                    cnt_d   = CNT_W'(1);
                    to_d    = 1'b0;
                end
            end
            HIGH: begin
                cnt_d = cnt_inc;
                if (fall) begin
                    high_tmp_d = cnt_q;
                    state_d    = LOW;
                end else if (at_lim) begin
                    state_d = IDLE;
                    cnt_d   = cnt_q;
                    to_d    = 1'b1;
                end
            end
            LOW: begin
                cnt_d = cnt_inc;
                if (rise) begin
                    // Closing rise of this period is the opening rise of
                    // the next one, so measurement continues in HIGH.
                    high_d  = high_tmp_q;
                    per_d   = cnt_q;
                    done_d  = 1'b1;
                    cnt_d   = CNT_W'(1);
                    state_d = HIGH;
                end else if (at_lim) begin
                    state_d = IDLE;
                    cnt_d   = cnt_q;
                    to_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign High_Count   = high_q;
    assign Period_Count = per_q;
    assign Done_Sig     = done_q;
    assign Timeout_Sig  = to_q;

endmodule

// File: tb/tb_pwm_capture_module.sv
`timescale 1ns/1ps
module tb_pwm_capture_module;

    localparam int CNT_W = 21;
    localparam int TTO   = 100;

    logic             CLK = 1'b0;
    logic             RSTn = 1'b0;
    logic             Sig_In = 1'b0;
    logic [CNT_W-1:0] High_Count, Period_Count;
    logic             Done_Sig, Timeout_Sig;

    int n_chk = 0;
    int n_fail = 0;

    pwm_capture_module #(.CNT_W(CNT_W), .T_TIMEOUT(21'd100)) dut (
        .CLK          (CLK),
        .RSTn         (RSTn),
        .Sig_In       (Sig_In),
        .High_Count   (High_Count),
        .Period_Count (Period_Count),
        .Done_Sig     (Done_Sig),
        .Timeout_Sig  (Timeout_Sig)
    );

    always #5 CLK = ~CLK;

    // Cycle index and observation queues (only ever appended to).
    int   cyc = 0;
    logic to_prev = 1'b0;
    int   d_cyc[$], d_hi[$], d_per[$];
    int   to_cyc[$];

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (Done_Sig === 1'b1) begin
            d_cyc.push_back(cyc);
            d_hi.push_back(int'(High_Count));
            d_per.push_back(int'(Period_Count));
        end
        if (Timeout_Sig === 1'b1 && to_prev !== 1'b1) to_cyc.push_back(cyc);
        to_prev <= Timeout_Sig;
    end

    // Stimulus description: list of (high, low) widths in cycles.
    int hq[$], lq[$];

    task automatic do_reset();
        Sig_In = 1'b0;
        RSTn   = 1'b0;
        repeat (3) @(negedge CLK);
        RSTn = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    // Drive level v at nominal cycle c after t0; jitter moves the edge to a
    // random point of the surrounding clock period (possibly past the next edge).
    task automatic put_edge(input longint t0, input int c, input logic v, input bit jit);
        longint t;
        int r, off;
        r   = int'($urandom % 13);
        off = jit ? ((r < 9) ? r + 1 : r + 2) : 5;
        t   = t0 + longint'(c) * 10 + longint'(off);
        if (t > $time) #(t - $time);
        Sig_In = v;
    endtask

    // Rise, then hq[i] high / lq[i] low for every entry, then a closing rise.
    task automatic drive_train(input bit jit);
        longint t0;
        int c;
        @(posedge CLK);
        t0 = $time;
        c  = 0;
        for (int i = 0; i < hq.size(); i++) begin
            put_edge(t0, c, 1'b1, jit);
            c += hq[i];
            put_edge(t0, c, 1'b0, jit);
            c += lq[i];
        end
        put_edge(t0, c, 1'b1, jit);
        repeat (6) @(negedge CLK);
    endtask

    task automatic test_reset();
        RSTn = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            Sig_In = ~Sig_In;
            n_chk++;
            if ({High_Count, Period_Count, Done_Sig, Timeout_Sig} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs cyc %0d: got hi=%0d per=%0d done=%b to=%b, need all 0",
                         i, High_Count, Period_Count, Done_Sig, Timeout_Sig);
            end
        end
        n_chk++;
        if (d_cyc.size() !== 0) begin
            n_fail++;
            $display("FAIL reset_no_done: got %0d done pulses, need 0", d_cyc.size());
        end
    endtask

    // Check the dones from index b against the model derived from hq/lq.
    task automatic test_periodic(input string nm, input int high_w, input int low_w, input int n);
        int b;
        do_reset();
        b = d_cyc.size();
        hq.delete(); lq.delete();
        for (int i = 0; i < n; i++) begin hq.push_back(high_w); lq.push_back(low_w); end
        drive_train(1'b0);
        n_chk++;
        if (d_cyc.size() - b !== n) begin
            n_fail++;
            $display("FAIL %s_count: got %0d dones, need %0d", nm, d_cyc.size() - b, n);
        end else begin
            for (int i = 0; i < n; i++) begin
                n_chk++;
                if (d_hi[b+i] !== high_w || d_per[b+i] !== high_w + low_w) begin
                    n_fail++;
                    $display("FAIL %s_result[%0d]: got %0d/%0d, need %0d/%0d", nm, i,
                             d_hi[b+i], d_per[b+i], high_w, high_w + low_w);
                end
                if (i > 0) begin
                    n_chk++;
                    if (d_cyc[b+i] - d_cyc[b+i-1] !== high_w + low_w) begin
                        n_fail++;
                        $display("FAIL %s_spacing[%0d]: got %0d, need %0d", nm, i,
                                 d_cyc[b+i] - d_cyc[b+i-1], high_w + low_w);
                    end
                end
            end
        end
        repeat (20) @(negedge CLK);
        n_chk++;
        if (int'(High_Count) !== high_w || int'(Period_Count) !== high_w + low_w ||
            Timeout_Sig !== 1'b0 || d_cyc.size() - b !== n) begin
            n_fail++;
            $display("FAIL %s_hold: got %0d/%0d to=%b dones=%0d, need %0d/%0d to=0 dones=%0d", nm,
                     High_Count, Period_Count, Timeout_Sig, d_cyc.size() - b,
                     high_w, high_w + low_w, n);
        end
    endtask

    task automatic test_timeout();
        int b, tb0;
        do_reset();
        b = d_cyc.size(); tb0 = to_cyc.size();
        hq = '{10}; lq = '{30};
        drive_train(1'b0);          // one done, then Sig_In stays high
        repeat (150) @(negedge CLK);
        n_chk++;
        if (Timeout_Sig !== 1'b1 || to_cyc.size() - tb0 !== 1) begin
            n_fail++;
            $display("FAIL timeout_level: got to=%b events=%0d, need to=1 events=1",
                     Timeout_Sig, to_cyc.size() - tb0);
        end else begin
            n_chk++;
            if (d_cyc.size() - b !== 1 || to_cyc[tb0] - d_cyc[b] !== TTO) begin
                n_fail++;
                $display("FAIL timeout_time: got dones=%0d delay=%0d, need dones=1 delay=%0d",
                         d_cyc.size() - b, to_cyc[tb0] - (d_cyc.size() > b ? d_cyc[b] : 0), TTO);
            end
        end
        n_chk++;
        if (int'(High_Count) !== 10 || int'(Period_Count) !== 40) begin
            n_fail++;
            $display("FAIL timeout_keep: got %0d/%0d, need 10/40", High_Count, Period_Count);
        end
        Sig_In = 1'b0;
        repeat (20) @(negedge CLK);
        n_chk++;
        if (Timeout_Sig !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_sticky: got to=%b, need 1", Timeout_Sig);
        end
        Sig_In = 1'b1;
        repeat (6) @(negedge CLK);
        n_chk++;
        if (Timeout_Sig !== 1'b0 || d_cyc.size() - b !== 1) begin
            n_fail++;
            $display("FAIL timeout_clear: got to=%b dones=%0d, need to=0 dones=1",
                     Timeout_Sig, d_cyc.size() - b);
        end
    endtask

    // Period exactly at the limit completes; one cycle more times out.
    task automatic test_boundary();
        int b, tb0;
        do_reset();
        b = d_cyc.size(); tb0 = to_cyc.size();
        hq = '{60}; lq = '{40};
        drive_train(1'b0);
        n_chk++;
        if (d_cyc.size() - b !== 1 || to_cyc.size() - tb0 !== 0) begin
            n_fail++;
            $display("FAIL limit_done: got dones=%0d timeouts=%0d, need 1/0",
                     d_cyc.size() - b, to_cyc.size() - tb0);
        end else begin
            n_chk++;
            if (d_hi[b] !== 60 || d_per[b] !== TTO) begin
                n_fail++;
                $display("FAIL limit_result: got %0d/%0d, need 60/%0d", d_hi[b], d_per[b], TTO);
            end
        end
        do_reset();
        b = d_cyc.size(); tb0 = to_cyc.size();
        hq = '{60}; lq = '{41};
        drive_train(1'b0);
        n_chk++;
        if (d_cyc.size() - b !== 0 || to_cyc.size() - tb0 !== 1) begin
            n_fail++;
            $display("FAIL over_limit: got dones=%0d timeouts=%0d, need 0/1",
                     d_cyc.size() - b, to_cyc.size() - tb0);
        end
        n_chk++;
        if (Timeout_Sig !== 1'b0 || High_Count !== '0 || Period_Count !== '0) begin
            n_fail++;
            $display("FAIL over_limit_state: got to=%b %0d/%0d, need to=0 0/0",
                     Timeout_Sig, High_Count, Period_Count);
        end
    endtask

    task automatic test_reset_mid();
        int b, nb;
        do_reset();
        b = d_cyc.size();
        hq = '{10, 10}; lq = '{30, 30};
        drive_train(1'b0);          // returns 6 cycles into a new high phase
        nb = d_cyc.size();
        @(negedge CLK);
        RSTn = 1'b0;
        @(negedge CLK);
        n_chk++;
        if ({High_Count, Period_Count, Done_Sig, Timeout_Sig} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %0d/%0d done=%b to=%b, need 0",
                     High_Count, Period_Count, Done_Sig, Timeout_Sig);
        end
        repeat (3) @(negedge CLK);
        Sig_In = 1'b0;
        repeat (10) @(negedge CLK);
        RSTn = 1'b1;
        repeat (5) @(negedge CLK);
        n_chk++;
        if (nb - b !== 2 || d_cyc.size() !== nb) begin
            n_fail++;
            $display("FAIL midreset_partial: got pre=%0d extra=%0d, need pre=2 extra=0",
                     nb - b, d_cyc.size() - nb);
        end
        drive_train(1'b0);
        n_chk++;
        if (d_cyc.size() - nb !== 2) begin
            n_fail++;
            $display("FAIL midreset_count: got %0d dones, need 2", d_cyc.size() - nb);
        end else begin
            n_chk++;
            if (d_hi[nb] !== 10 || d_per[nb] !== 40) begin
                n_fail++;
                $display("FAIL midreset_first: got %0d/%0d, need 10/40", d_hi[nb], d_per[nb]);
            end
        end
    endtask

    // Random widths; exact without jitter, within one cycle with jitter.
    task automatic test_random(input bit jit);
        int b, tol, n, eh, ep, dh, dp;
        n   = 8;
        tol = jit ? 1 : 0;
        do_reset();
        b = d_cyc.size();
        hq.delete(); lq.delete();
        for (int i = 0; i < n; i++) begin
            hq.push_back(int'($urandom_range(40, 2)));
            lq.push_back(int'($urandom_range(50, 2)));
        end
        drive_train(jit);
        n_chk++;
        if (d_cyc.size() - b !== n) begin
            n_fail++;
            $display("FAIL random%0d_count: got %0d dones, need %0d", jit, d_cyc.size() - b, n);
        end else begin
            for (int i = 0; i < n; i++) begin
                eh = hq[i];
                ep = hq[i] + lq[i];
                dh = d_hi[b+i] - eh;
                dp = d_per[b+i] - ep;
                n_chk++;
                if (dh > tol || dh < -tol || dp > tol || dp < -tol) begin
                    n_fail++;
                    $display("FAIL random%0d_result[%0d]: got %0d/%0d, need %0d/%0d (+/-%0d)",
                             jit, i, d_hi[b+i], d_per[b+i], eh, ep, tol);
                end
            end
        end
        n_chk++;
        if (Timeout_Sig !== 1'b0) begin
            n_fail++;
            $display("FAIL random%0d_timeout: got to=%b, need 0", jit, Timeout_Sig);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, need normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_periodic("pwm", 10, 30, 4);
        test_periodic("min", 1, 1, 6);
        test_timeout();
        test_boundary();
        test_reset_mid();
        test_random(1'b0);
        test_random(1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
